seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Parametrised, registered ALU for the next tinySoC core. Adds iterative MUL/DIVU,
//  barrel shifts by operand B, and an overflow flag to the existing op set.
//  Sits between register-file read and writeback; valid/ready on both sides lets
//  the core stall during multi-cycle ops.
// PARAMETERS
//  WIDTH    8               datapath width in bits (>=4)
//  SHAMT_W  $clog2(WIDTH)   shift-amount bits taken from data_b
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands/mode valid
//  in_ready   out  1      unit can accept; transfer when in_valid & in_ready
//  mode       in   4      operation code (see BEHAVIOUR)
//  data_a     in   WIDTH  operand A
//  data_b     in   WIDTH  operand B
//  cin        in   1      carry/borrow in
//  out_valid  out  1      result/flags valid; held until out_ready
//  out_ready  in   1      consumer accepts; transfer when out_valid & out_ready
//  out        out  WIDTH  result (MUL low half, DIVU quotient)
//  out_hi     out  WIDTH  MUL high half, DIVU remainder; 0 for all other ops
//  cout       out  1      carry/borrow
//  zout       out  1      zero
//  nout       out  1      negative
//  vout       out  1      signed overflow (ADD/ADC/SUB/SBB); DIVU divide-by-zero
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1, out_valid=0, out/out_hi=0, cout/zout/nout/vout=0.
//  Modes: 0 PASSB, 1 AND, 2 OR, 3 XOR, 4 ADD, 5 ADC, 6 CMP, 7 SUB, 8 SBB, 9 NOT(A),
//   10 SHL A by B[SHAMT_W-1:0], 11 SHR logical, 12 SRA arithmetic, 13 PASSA,
//   14 MUL unsigned, 15 DIVU unsigned.
//  Arithmetic: ADD/ADC/SUB/SBB computed in WIDTH+1 bits; cout = bit WIDTH
//   (for SUB/SBB it is the borrow). vout = sign of A and +/-B agree and differ
//   from result sign.
//  Logic, NOT, PASS, shifts: cout=cin, vout=0. Shifts by 0 return A unchanged.
//  CMP: out=A, cout=(A<B unsigned), zout=(A==B), nout=(A<B signed), vout=0.
//  All other ops: zout=(out==0), nout=out[WIDTH-1].
//  FSM IDLE/BUSY/DONE:
//   IDLE: in_ready=1. Accept of modes 0-13 -> DONE; result registered, so
//     out_valid rises the cycle after accept (latency 1).
//   Accept of 14/15 -> BUSY; in_ready=0; iteration counter loaded with WIDTH-1.
//   BUSY: one shift-add (MUL) or restoring-subtract (DIVU) step per cycle;
//     counter reaching 0 -> DONE. MUL/DIVU latency = WIDTH+1 cycles accept->out_valid.
//   DONE: out_valid=1, outputs stable. On out_ready -> IDLE. Same-cycle
//     back-to-back: in_ready = !out_valid | out_ready, so a new op may be accepted
//     in the cycle the old result is taken (full throughput for 1-cycle ops).
//  MUL: {out_hi,out} = A*B (2*WIDTH bits); cout=(out_hi!=0); vout=0.
//  DIVU: out=A/B, out_hi=A%B. B==0: out=all-ones, out_hi=A, vout=1, cout=cin.
//   Detected at accept; still takes full WIDTH+1 latency (fixed timing).
//  Operands/mode/cin are captured at accept; later input changes are ignored.
//  in_valid while BUSY/DONE-unaccepted is not accepted (in_ready=0).
//  Reset asserted mid-operation aborts immediately to reset state; no result.
// STRUCTURE
//  Package alu_pkg: ALU_* mode localparams (4-bit), FSM state encoding.
//  Sub-module seq_alu_muldiv: iterative MUL/DIVU engine (start, op, a, b ->
//   done, lo, hi, div0); seq_alu owns handshake, FSM, 1-cycle ops and flags.
// TESTING (WIDTH=8 unless stated)
//  ADD A=0x7F B=0x01 -> out=0x80, cout=0, vout=1, nout=1, out_valid 1 cycle after accept.
//  SBB A=0x00 B=0x00 cin=1 -> out=0xFF, cout=1, zout=0; CMP A=0x80 B=0x01 -> cout=0, nout=1.
//  MUL A=0xFF B=0xFF -> out=0x01, out_hi=0xFE, cout=1; out_valid exactly 9 cycles after accept, in_ready=0 throughout.
//  DIVU A=100 B=7 -> out=14, out_hi=2; DIVU A=0x55 B=0 -> out=0xFF, out_hi=0x55, vout=1.
//  Backpressure: hold out_ready=0 5 cycles -> outputs stable, in_ready=0; stream 4 ADDs with out_ready=1 -> one result per cycle.
//  rst_n low during MUL BUSY -> all outputs 0, in_ready=1 async; next op completes correctly. WIDTH=16 SRA 0x8000 by 15 -> 0xFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared mode codes and FSM encoding for the sequential ALU.
package alu_pkg;

   localparam logic [3:0] ALU_PASSB = 4'd0;
   localparam logic [3:0] ALU_AND   = 4'd1;
   localparam logic [3:0] ALU_OR    = 4'd2;
   localparam logic [3:0] ALU_XOR   = 4'd3;
   localparam logic [3:0] ALU_ADD   = 4'd4;
   localparam logic [3:0] ALU_ADC   = 4'd5;
   localparam logic [3:0] ALU_CMP   = 4'd6;
   localparam logic [3:0] ALU_SUB   = 4'd7;
   localparam logic [3:0] ALU_SBB   = 4'd8;
   localparam logic [3:0] ALU_NOT   = 4'd9;
   localparam logic [3:0] ALU_SHL   = 4'd10;
   localparam logic [3:0] ALU_SHR   = 4'd11;
   localparam logic [3:0] ALU_SRA   = 4'd12;
   localparam logic [3:0] ALU_PASSA = 4'd13;
   localparam logic [3:0] ALU_MUL   = 4'd14;
   localparam logic [3:0] ALU_DIVU  = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
module seq_alu_muldiv #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_op_div,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done_c,
   output logic [WIDTH-1:0] o_lo_c,
   output logic [WIDTH-1:0] o_hi_c,
   output logic             o_div0
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic             r_busy;
   logic             r_op_div;
   logic             r_div0;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_m;
   logic [WIDTH-1:0] r_a;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_t;
   logic             w_ge;
   logic [WIDTH-1:0] w_d;
   logic [WIDTH-1:0] w_hi_next;
   logic [WIDTH-1:0] w_lo_next;

   // One iteration step: {hi,lo} is the product/partial-remainder:quotient pair.
   always_comb begin
      w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
      w_t       = {r_hi, r_lo[WIDTH-1]};
      w_ge      = (w_t >= {1'b0, r_m});
      w_d       = w_ge ? WIDTH'(w_t - {1'b0, r_m}) : w_t[WIDTH-1:0];
      w_hi_next = w_sum[WIDTH:1];
      w_lo_next = {w_sum[0], r_lo[WIDTH-1:1]};
      if (r_op_div) begin
         w_hi_next = w_d;
         w_lo_next = {r_lo[WIDTH-2:0], w_ge};
      end
   end

   // Load operands on start, then step until the counter expires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy   <= 1'b0;
         r_op_div <= 1'b0;
         r_div0   <= 1'b0;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_m      <= '0;
         r_a      <= '0;
      end else if (i_start) begin
         r_busy   <= 1'b1;
         r_op_div <= i_op_div;
         r_div0   <= i_op_div && (i_b == '0);
         r_cnt    <= CNT_W'(WIDTH - 1);
         r_hi     <= '0;
         r_lo     <= i_op_div ? i_a : i_b;
         r_m      <= i_op_div ? i_b : i_a;
         r_a      <= i_a;
      end else if (r_busy) begin
         r_hi <= w_hi_next;
         r_lo <= w_lo_next;
         if (r_cnt == '0) r_busy <= 1'b0;
         else             r_cnt  <= r_cnt - CNT_W'(1);
      end
   end

   // Final-step result is presented combinationally so the top can register it.
   assign o_done_c = r_busy && (r_cnt == '0);
   assign o_lo_c   = r_div0 ? '1  : w_lo_next;
   assign o_hi_c   = r_div0 ? r_a : w_hi_next;
   assign o_div0   = r_div0;

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake; 1-cycle ops plus iterative MUL/DIVU.
module seq_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       mode,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_hi,
   output logic             cout,
   output logic             zout,
   output logic             nout,
   output logic             vout
);

   state_t           r_state;
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_hi;
   logic             r_c, r_z, r_n, r_v;
   logic [3:0]       r_mode;
   logic             r_cin;

   logic             w_accept;
   logic             w_multi;
   logic [WIDTH:0]   w_arith;
   logic [SHAMT_W-1:0] w_shamt;
   logic [WIDTH-1:0] w_res;
   logic             w_c, w_z, w_n, w_v;
   logic             w_is_add, w_is_sub;
   logic             w_done_c;
   logic [WIDTH-1:0] w_lo_c;
   logic [WIDTH-1:0] w_hi_c;
   logic             w_div0;
   logic             w_md_c, w_md_v;

   assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
   assign out_valid = (r_state == ST_DONE);
   assign w_accept  = in_valid && in_ready;
   assign w_multi   = (mode == ALU_MUL) || (mode == ALU_DIVU);

   // Single-cycle result and flags from the live operands.
   always_comb begin
      w_res    = '0;
      w_arith  = '0;
      w_c      = cin;
      w_v      = 1'b0;
      w_shamt  = data_b[SHAMT_W-1:0];
      w_is_add = (mode == ALU_ADD) || (mode == ALU_ADC);
      w_is_sub = (mode == ALU_SUB) || (mode == ALU_SBB);
      case (mode)
         ALU_PASSB: w_res = data_b;
         ALU_AND:   w_res = data_a & data_b;
         ALU_OR:    w_res = data_a | data_b;
         ALU_XOR:   w_res = data_a ^ data_b;
         ALU_ADD:   w_arith = {1'b0, data_a} + {1'b0, data_b};
         ALU_ADC:   w_arith = {1'b0, data_a} + {1'b0, data_b} + (WIDTH+1)'(cin);
         ALU_SUB:   w_arith = {1'b0, data_a} - {1'b0, data_b};
         ALU_SBB:   w_arith = {1'b0, data_a} - {1'b0, data_b} - (WIDTH+1)'(cin);
         ALU_CMP:   w_res = data_a;
         ALU_NOT:   w_res = ~data_a;
         ALU_SHL:   w_res = data_a << w_shamt;
         ALU_SHR:   w_res = data_a >> w_shamt;
         ALU_SRA:   w_res = $unsigned($signed(data_a) >>> w_shamt);
         ALU_PASSA: w_res = data_a;
         default:   w_res = '0;
      endcase
      if (w_is_add || w_is_sub) begin
         w_res = w_arith[WIDTH-1:0];
         w_c   = w_arith[WIDTH];
         w_v   = ((data_a[WIDTH-1] == data_b[WIDTH-1]) == w_is_add) &&
                 (w_res[WIDTH-1] != data_a[WIDTH-1]);
      end
      w_z = (w_res == '0);
      w_n = w_res[WIDTH-1];
      if (mode == ALU_CMP) begin
         w_c = (data_a < data_b);
         w_z = (data_a == data_b);
         w_n = ($signed(data_a) < $signed(data_b));
         w_v = 1'b0;
      end
   end

   seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_start  (w_accept && w_multi),
      .i_op_div (mode == ALU_DIVU),
      .i_a      (data_a),
      .i_b      (data_b),
      .o_done_c (w_done_c),
      .o_lo_c   (w_lo_c),
      .o_hi_c   (w_hi_c),
      .o_div0   (w_div0)
   );

   // Flags for the iterative ops, using the mode/carry captured at accept.
   always_comb begin
      w_md_c = (w_hi_c != '0);
      w_md_v = 1'b0;
      if (r_mode == ALU_DIVU) begin
         w_md_c = r_cin;
         w_md_v = w_div0;
      end
   end

   // Handshake FSM with registered result and flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_out   <= '0;
         r_hi    <= '0;
         r_c     <= 1'b0;
         r_z     <= 1'b0;
         r_n     <= 1'b0;
         r_v     <= 1'b0;
         r_mode  <= '0;
         r_cin   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_accept) begin
                  if (w_multi) begin
                     r_state <= ST_BUSY;
                     r_mode  <= mode;
                     r_cin   <= cin;
                  end else begin
                     r_state <= ST_DONE;
                     r_out   <= w_res;
                     r_hi    <= '0;
                     r_c     <= w_c;
                     r_z     <= w_z;
                     r_n     <= w_n;
                     r_v     <= w_v;
                  end
               end else if ((r_state == ST_DONE) && out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (w_done_c) begin
                  r_state <= ST_DONE;
                  r_out   <= w_lo_c;
                  r_hi    <= w_hi_c;
                  r_c     <= w_md_c;
                  r_z     <= (w_lo_c == '0);
                  r_n     <= w_lo_c[WIDTH-1];
                  r_v     <= w_md_v;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out    = r_out;
   assign out_hi = r_hi;
   assign cout   = r_c;
   assign zout   = r_z;
   assign nout   = r_n;
   assign vout   = r_v;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=8 main instance, WIDTH=16 for wide shift).
module tb_seq_alu;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, cin;
   logic [3:0]  mode;
   logic [7:0]  data_a, data_b, out, out_hi;
   logic        cout, zout, nout, vout;

   logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_cin;
   logic [3:0]  w_mode;
   logic [15:0] w_data_a, w_data_b, w_out, w_out_hi;
   logic        w_cout, w_zout, w_nout, w_vout;

   int checks = 0;
   int errors = 0;
   int lat;
   logic busy_ok;

   seq_alu #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .data_a(data_a), .data_b(data_b), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_hi(out_hi),
      .cout(cout), .zout(zout), .nout(nout), .vout(vout)
   );

   seq_alu #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
      .mode(w_mode), .data_a(w_data_a), .data_b(w_data_b), .cin(w_cin),
      .out_valid(w_out_valid), .out_ready(w_out_ready), .out(w_out), .out_hi(w_out_hi),
      .cout(w_cout), .zout(w_zout), .nout(w_nout), .vout(w_vout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b,
                        input logic ci);
      mode = m; data_a = a; data_b = b; cin = ci; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      data_a = 8'h00; data_b = 8'h00; cin = 1'b0;
   endtask

   // Counts cycles from accept to out_valid; sample right after accept is latency 1.
   task automatic wait_valid(output int l, output logic ok);
      l = 1;
      ok = 1'b1;
      while (!out_valid && l < 40) begin
         if (in_ready !== 1'b0) ok = 1'b0;
         step();
         l++;
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = 4'd0;
      data_a = 8'h00; data_b = 8'h00; cin = 1'b0;
      w_in_valid = 1'b0; w_out_ready = 1'b1; w_mode = 4'd0;
      w_data_a = 16'h0; w_data_b = 16'h0; w_cin = 1'b0;
      #3;
      check("reset_hs",    32'({in_ready, out_valid}), 32'h2);
      check("reset_data",  32'({out, out_hi}), 32'h0);
      check("reset_flags", 32'({cout, zout, nout, vout}), 32'h0);
      step();
      rst_n = 1'b1;
      step();

      // Wide arithmetic shift on the 16-bit instance
      w_mode = ALU_SRA; w_data_a = 16'h8000; w_data_b = 16'h000F; w_in_valid = 1'b1;
      step();
      w_in_valid = 1'b0;
      check("w16_sra", 32'({w_out_valid, w_out}), 32'h1FFFF);

      issue(ALU_ADD, 8'h7F, 8'h01, 1'b0);
      check("add_valid_lat1", 32'(out_valid), 32'h1);
      check("add_out",   32'({out_hi, out}), 32'h0080);
      check("add_flags", 32'({cout, zout, nout, vout}), 32'b0011);

      issue(ALU_SBB, 8'h00, 8'h00, 1'b1);
      check("sbb_out",   32'(out), 32'hFF);
      check("sbb_flags", 32'({cout, zout, nout, vout}), 32'b1010);

      issue(ALU_CMP, 8'h80, 8'h01, 1'b1);
      check("cmp_out",   32'(out), 32'h80);
      check("cmp_flags", 32'({cout, zout, nout, vout}), 32'b0010);

      issue(ALU_SUB, 8'h05, 8'h05, 1'b1);
      check("sub_zero", 32'({out, cout, zout, nout, vout}), 32'h004);

      issue(ALU_ADC, 8'hFF, 8'h01, 1'b1);
      check("adc_carry", 32'({out, cout, zout, nout, vout}), 32'h018);

      issue(ALU_XOR, 8'hA5, 8'hFF, 1'b1);
      check("xor_cin", 32'({out, cout, zout, nout, vout}), 32'h5A8);

      issue(ALU_SHL, 8'h81, 8'h09, 1'b0);
      check("shl_by1", 32'({out, cout, zout, nout, vout}), 32'h020);

      issue(ALU_SHR, 8'h80, 8'h00, 1'b0);
      check("shr_by0", 32'({out, cout, zout, nout, vout}), 32'h802);

      issue(ALU_SRA, 8'h80, 8'h03, 1'b0);
      check("sra_by3", 32'({out, cout, zout, nout, vout}), 32'hF02);

      issue(ALU_NOT, 8'hFF, 8'h00, 1'b0);
      check("not_zero", 32'({out, cout, zout, nout, vout}), 32'h004);

      issue(ALU_PASSB, 8'h11, 8'h3C, 1'b0);
      check("passb", 32'({out_hi, out}), 32'h003C);

      issue(ALU_MUL, 8'hFF, 8'hFF, 1'b0);
      wait_valid(lat, busy_ok);
      check("mul_latency",  32'(lat), 32'd9);
      check("mul_busy_rdy", 32'(busy_ok), 32'h1);
      check("mul_result",   32'({out_hi, out}), 32'hFE01);
      check("mul_flags",    32'({cout, zout, nout, vout}), 32'b1000);
      step();

      issue(ALU_DIVU, 8'd100, 8'd7, 1'b0);
      wait_valid(lat, busy_ok);
      check("div_latency", 32'(lat), 32'd9);
      check("div_result",  32'({out_hi, out}), 32'h020E);
      check("div_flags",   32'({cout, zout, nout, vout}), 32'b0000);
      step();

      issue(ALU_DIVU, 8'h55, 8'h00, 1'b1);
      wait_valid(lat, busy_ok);
      check("div0_latency", 32'(lat), 32'd9);
      check("div0_result",  32'({out_hi, out}), 32'h55FF);
      check("div0_flags",   32'({cout, zout, nout, vout}), 32'b1011);
      step();

      // Backpressure: result must hold while a competing request is refused
      out_ready = 1'b0;
      issue(ALU_ADD, 8'h10, 8'h20, 1'b0);
      mode = ALU_ADD; data_a = 8'h01; data_b = 8'h01; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_hold", 32'({out_valid, in_ready, out}), 32'h230);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      check("bp_release", 32'({out_valid, in_ready}), 32'h1);

      // Back-to-back stream of single-cycle ops
      for (int i = 0; i < 4; i++) begin
         mode = ALU_ADD; data_a = 8'(i * 3 + 1); data_b = 8'h40; in_valid = 1'b1;
         step();
         check("stream", 32'({out_valid, out}), 32'h100 | 32'(8'(i * 3 + 65)));
      end
      in_valid = 1'b0;
      step();
      check("stream_end", 32'(out_valid), 32'h0);

      // Reset in the middle of a multiply
      issue(ALU_MUL, 8'h12, 8'h34, 1'b0);
      step();
      step();
      rst_n = 1'b0;
      #1;
      check("midrst_hs",    32'({in_ready, out_valid}), 32'h2);
      check("midrst_data",  32'({out_hi, out}), 32'h0);
      check("midrst_flags", 32'({cout, zout, nout, vout}), 32'h0);
      #2;
      rst_n = 1'b1;
      step();
      issue(ALU_MUL, 8'h12, 8'h34, 1'b0);
      wait_valid(lat, busy_ok);
      check("post_rst_mul_lat", 32'(lat), 32'd9);
      check("post_rst_mul",     32'({out_hi, out}), 32'h03A8);
      check("post_rst_flags",   32'({cout, zout, nout, vout}), 32'b1010);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
